// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder that streams encoded words into instruction memory over a WE/ACK handshake.
// Optional immediate/mnemonic legality flag enabled with `define ILLEGAL_CHECK_EN (default build: o_err tied low).
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_mnem,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    input  logic              i_clr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a field set is taken on a rising edge where i_in_valid && o_in_ready;
    // a memory write is pending while o_mem_we is high and completes on the edge i_mem_ack is high.

    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [3:0] M_ADDI = 4'd0;
    localparam logic [3:0] M_ANDI = 4'd1;
    localparam logic [3:0] M_XORI = 4'd2;
    localparam logic [3:0] M_SLLI = 4'd3;
    localparam logic [3:0] M_SRAI = 4'd4;
    localparam logic [3:0] M_LW   = 4'd5;
    localparam logic [3:0] M_JALR = 4'd6;
    localparam logic [3:0] M_SW   = 4'd7;
    localparam logic [3:0] M_ADD  = 4'd8;
    localparam logic [3:0] M_SUB  = 4'd9;
    localparam logic [3:0] M_SLL  = 4'd10;
    localparam logic [3:0] M_LUI  = 4'd11;
    localparam logic [3:0] M_BNE  = 4'd12;
    localparam logic [3:0] M_BGE  = 4'd13;
    localparam logic [3:0] M_JAL  = 4'd14;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_full;

    logic [31:0]         w_encoded;
    logic                w_accept;
    logic                w_clear;
    logic [ADDR_W:0]     w_count_next;

    // CLR wins over a same-cycle accept; a write in flight is never cut short by CLR.
    assign w_clear      = i_clr && (r_state != ST_WRITE);
    assign w_accept     = (r_state == ST_IDLE) && r_in_ready && i_in_valid && !i_clr;
    assign w_count_next = r_count + 1'b1;

    always_comb begin
        w_encoded = NOP_WORD;
        case (i_mnem)
            M_ADDI: w_encoded = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_IMM};
            M_ANDI: w_encoded = {i_imm[11:0], i_rs1, 3'b111, i_rd, OP_IMM};
            M_XORI: w_encoded = {i_imm[11:0], i_rs1, 3'b100, i_rd, OP_IMM};
            M_SLLI: w_encoded = {F7_ZERO, i_imm[4:0], i_rs1, 3'b001, i_rd, OP_IMM};
            M_SRAI: w_encoded = {F7_ALT, i_imm[4:0], i_rs1, 3'b101, i_rd, OP_IMM};
            M_LW:   w_encoded = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LOAD};
            M_JALR: w_encoded = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
            M_SW:   w_encoded = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_STORE};
            M_ADD:  w_encoded = {F7_ZERO, i_rs2, i_rs1, 3'b000, i_rd, OP_REG};
            M_SUB:  w_encoded = {F7_ALT, i_rs2, i_rs1, 3'b000, i_rd, OP_REG};
            M_SLL:  w_encoded = {F7_ZERO, i_rs2, i_rs1, 3'b001, i_rd, OP_REG};
            M_LUI:  w_encoded = {i_imm[31:12], i_rd, OP_LUI};
            M_BNE:  w_encoded = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b001,
                                 i_imm[4:1], i_imm[11], OP_BRANCH};
            M_BGE:  w_encoded = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b101,
                                 i_imm[4:1], i_imm[11], OP_BRANCH};
            M_JAL:  w_encoded = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
            default: w_encoded = NOP_WORD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE;
            r_mem_wdata <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_clear) begin
                        r_mem_addr <= BASE;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else if (w_accept) begin
                        r_mem_wdata <= w_encoded;
                        r_mem_we    <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ack) begin
                        r_mem_we   <= 1'b0;
                        r_count    <= w_count_next;
                        r_mem_addr <= r_mem_addr + 1'b1;
                        if (w_count_next == CAPACITY) begin
                            r_state    <= ST_FULL;
                            r_full     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // Address has already wrapped to BASE; only CLR reopens the buffer.
                    if (w_clear) begin
                        r_state    <= ST_IDLE;
                        r_mem_addr <= BASE;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_mem_we   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ILLEGAL_CHECK_EN
    logic r_err;
    logic w_illegal;
    logic w_fits_12;
    logic w_fits_13;
    logic w_fits_21;

    assign w_fits_12 = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
    assign w_fits_13 = (i_imm[31:12] == '0) || (i_imm[31:12] == '1);
    assign w_fits_21 = (i_imm[31:20] == '0) || (i_imm[31:20] == '1);

    always_comb begin
        w_illegal = 1'b0;
        case (i_mnem)
            M_ADDI, M_ANDI, M_XORI, M_LW, M_JALR, M_SW: w_illegal = !w_fits_12;
            M_SLLI, M_SRAI:                             w_illegal = |i_imm[31:5];
            M_BNE, M_BGE:                               w_illegal = !w_fits_13 || i_imm[0];
            M_JAL:                                      w_illegal = !w_fits_21 || i_imm[0];
            M_ADD, M_SUB, M_SLL, M_LUI:                 w_illegal = 1'b0;
            default:                                    w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clear) begin
            r_err <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_count     = r_count;
    assign o_full      = r_full;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of hand-encoded RV32I words plus multi-cycle corner sequences.
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 1;
    localparam int CAP       = 4;
`ifdef ILLEGAL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mnem;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              clr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_mnem(mnem), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_clr(clr),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
        .o_count(count), .o_full(full), .o_err(err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        int          ack_delay;
        logic [31:0] exp_word;
        logic        bad;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input int cnt);
        exp_addr = ADDR_W'((BASE_ADDR + cnt) % CAP);
    endfunction

    task automatic wait_ready;
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Presents one field set and returns just after the accepting edge.
    task automatic send(input int idx);
        wait_ready();
        mnem = vecs[idx].mnem; rd = vecs[idx].rd; rs1 = vecs[idx].rs1;
        rs2 = vecs[idx].rs2; imm = vecs[idx].imm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic ack_now;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    int  exp_count;
    logic exp_err;

    initial begin
        //                mnem   rd     rs1    rs2    imm             dly word          bad
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd0,  32'd5,          0, 32'h00510093, 1'b0};
        vecs[1]  = '{4'd9,  5'd3,  5'd1,  5'd2,  32'd0,          0, 32'h402081B3, 1'b0};
        vecs[2]  = '{4'd11, 5'd5,  5'd0,  5'd0,  32'h12345000,   1, 32'h123452B7, 1'b0};
        vecs[3]  = '{4'd7,  5'd0,  5'd1,  5'd2,  32'd8,          0, 32'h0020A423, 1'b0};
        vecs[4]  = '{4'd12, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,   3, 32'hFE209EE3, 1'b0};
        vecs[5]  = '{4'd1,  5'd7,  5'd3,  5'd0,  32'h000000FF,   0, 32'h0FF1F393, 1'b0};
        vecs[6]  = '{4'd2,  5'd4,  5'd4,  5'd0,  32'hFFFFFFFF,   2, 32'hFFF24213, 1'b0};
        vecs[7]  = '{4'd3,  5'd6,  5'd6,  5'd0,  32'd31,         0, 32'h01F31313, 1'b0};
        vecs[8]  = '{4'd4,  5'd8,  5'd9,  5'd0,  32'd3,          0, 32'h4034D413, 1'b0};
        vecs[9]  = '{4'd5,  5'd10, 5'd2,  5'd0,  32'd16,         1, 32'h01012503, 1'b0};
        vecs[10] = '{4'd6,  5'd1,  5'd5,  5'd0,  32'hFFFFFFF8,   0, 32'hFF8280E7, 1'b0};
        vecs[11] = '{4'd8,  5'd11, 5'd12, 5'd13, 32'd0,          0, 32'h00D605B3, 1'b0};
        vecs[12] = '{4'd10, 5'd31, 5'd30, 5'd29, 32'd0,          0, 32'h01DF1FB3, 1'b0};
        vecs[13] = '{4'd13, 5'd0,  5'd3,  5'd4,  32'd16,         0, 32'h0041D863, 1'b0};
        vecs[14] = '{4'd14, 5'd1,  5'd0,  5'd0,  32'd2048,       0, 32'h001000EF, 1'b0};
        vecs[15] = '{4'd15, 5'd9,  5'd9,  5'd9,  32'h0000FFFF,   0, 32'h00000013, 1'b1};
        vecs[16] = '{4'd0,  5'd0,  5'd0,  5'd0,  32'd2048,       0, 32'h80000013, 1'b1};

        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; mem_ack = 1'b0;
        mnem = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) tick();
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {30'd0, mem_addr}, BASE_ADDR);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        exp_count = 0;
        exp_err   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(i);
            check($sformatf("v%0d_we", i), {31'd0, mem_we}, 32'd1);
            check($sformatf("v%0d_addr", i), {30'd0, mem_addr}, {30'd0, exp_addr(exp_count)});
            check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_word);
            check($sformatf("v%0d_busy", i), {31'd0, in_ready}, 32'd0);
            for (int d = 0; d < vecs[i].ack_delay; d++) begin
                tick();
                check($sformatf("v%0d_hold_we", i), {31'd0, mem_we}, 32'd1);
                check($sformatf("v%0d_hold_addr", i), {30'd0, mem_addr}, {30'd0, exp_addr(exp_count)});
                check($sformatf("v%0d_hold_wdata", i), mem_wdata, vecs[i].exp_word);
            end
            ack_now();
            exp_count++;
            if (CHECK_EN && vecs[i].bad) exp_err = 1'b1;
            check($sformatf("v%0d_we_drop", i), {31'd0, mem_we}, 32'd0);
            check($sformatf("v%0d_count", i), {29'd0, count}, exp_count);
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, exp_err});
            if (exp_count == CAP) begin
                check("full_flag", {31'd0, full}, 32'd1);
                check("full_ready", {31'd0, in_ready}, 32'd0);
                check("full_addr_wrap", {30'd0, mem_addr}, BASE_ADDR);
                in_valid = 1'b1;
                tick();
                tick();
                in_valid = 1'b0;
                check("full_ignore_we", {31'd0, mem_we}, 32'd0);
                check("full_ignore_count", {29'd0, count}, CAP);
                clr = 1'b1;
                tick();
                clr = 1'b0;
                exp_count = 0;
                exp_err   = 1'b0;
                check("clr_count", {29'd0, count}, 32'd0);
                check("clr_full", {31'd0, full}, 32'd0);
                check("clr_addr", {30'd0, mem_addr}, BASE_ADDR);
                check("clr_ready", {31'd0, in_ready}, 32'd1);
                check("clr_err", {31'd0, err}, 32'd0);
            end else begin
                check($sformatf("v%0d_ready", i), {31'd0, in_ready}, 32'd1);
                check($sformatf("v%0d_notfull", i), {31'd0, full}, 32'd0);
            end
        end

        // MEM_ACK while idle must not count anything.
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("idle_ack_count", {29'd0, count}, 32'd1);
        check("idle_ack_we", {31'd0, mem_we}, 32'd0);

        // CLR during WRITE is ignored and the write completes.
        send(0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_in_write_we", {31'd0, mem_we}, 32'd1);
        check("clr_in_write_count", {29'd0, count}, 32'd1);
        ack_now();
        check("clr_in_write_done", {29'd0, count}, 32'd2);
        check("clr_in_write_addr", {30'd0, mem_addr}, {30'd0, exp_addr(2)});
        check("clr_in_write_err", {31'd0, err}, {31'd0, CHECK_EN});

        // CLR and accept in the same cycle: CLR wins, illegal fields dropped.
        wait_ready();
        mnem = 4'd15; imm = '0;
        in_valid = 1'b1;
        clr = 1'b1;
        tick();
        in_valid = 1'b0;
        clr = 1'b0;
        check("clr_vs_accept_we", {31'd0, mem_we}, 32'd0);
        check("clr_vs_accept_count", {29'd0, count}, 32'd0);
        check("clr_vs_accept_addr", {30'd0, mem_addr}, BASE_ADDR);
        check("clr_vs_accept_err", {31'd0, err}, 32'd0);
        check("clr_vs_accept_ready", {31'd0, in_ready}, 32'd1);

        // RST while a write is pending aborts it.
        send(1);
        ack_now();
        check("pre_rst_count", {29'd0, count}, 32'd1);
        send(2);
        tick();
        check("pre_rst_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_write_we", {31'd0, mem_we}, 32'd0);
        check("rst_write_count", {29'd0, count}, 32'd0);
        check("rst_write_addr", {30'd0, mem_addr}, BASE_ADDR);
        check("rst_write_wdata", mem_wdata, 32'd0);
        check("rst_write_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_write_ready_after", {31'd0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
